edge_pixel_packer: RTL and testbench
====================================

// Module: edge_pixel_packer
// PURPOSE
//  Drains the 8-bit Sobel output FIFO of the edge-detect pipeline (empty/rd_en/dout side).
//  Packs four pixels into one 32-bit word and writes it to a downstream 32-bit FIFO (full/wr_en/din side).
//  Tracks column/row position over a WIDTH x HEIGHT frame and zero-pads the final partial word of each frame.
//  Reports the per-frame count of edge pixels >= THRESHOLD together with a one-cycle frame_done pulse.
// PARAMETERS
//  WIDTH      720  pixels per row
//  HEIGHT     540  rows per frame
//  THRESHOLD  128  edge pixel counted when in_dout >= THRESHOLD (unsigned 8-bit compare)
//  CNT_W      $clog2(WIDTH*HEIGHT+1)  width of edge_count
// PORTS
//  clock       in   1      single clock, rising edge
//  reset       in   1      synchronous, active-high
//  in_dout     in   8      pixel at head of input FIFO (first-word-fall-through: valid while !in_empty)
//  in_empty    in   1      input FIFO empty
//  in_rd_en    out  1      pop input FIFO; in_dout consumed in the same cycle
//  out_din     out  32     packed word; pixel k of the word in bits [8k+7:8k], first pixel in [7:0]
//  out_full    in   1      output FIFO full
//  out_wr_en   out  1      write out_din into the output FIFO this cycle
//  frame_done  out  1      one-cycle pulse in the cycle after the last word of a frame is written
//  edge_count  out  CNT_W  edge-pixel count of the last completed frame; holds until the next frame_done
// BEHAVIOUR
//  - FSM states: S_COLLECT, S_EMIT. Reset -> S_COLLECT, with col=0, row=0, byte_idx=0, word=0, acc_cnt=0.
//  - Reset values: out_din=0, out_wr_en=0, in_rd_en=0, frame_done=0, edge_count=0.
//  - S_COLLECT:
//      - in_rd_en = !in_empty (combinational).
//      - On a pop: word[8*byte_idx +: 8] <= in_dout; byte_idx++.
//      - On a pop: acc_cnt increments when in_dout >= THRESHOLD.
//      - On a pop: col advances; at col == WIDTH-1, col wraps to 0 and row++.
//      - last_px = (col == WIDTH-1 && row == HEIGHT-1) on the popped pixel.
//      - Go to S_EMIT when byte_idx == 3 or last_px.
//      - On last_px, unwritten upper bytes of the word are 0 (the word is cleared at the start of each word).
//  - S_EMIT:
//      - in_rd_en = 0; out_wr_en = !out_full (combinational); out_din = word (registered, stable).
//      - On a write: clear word and byte_idx, return to S_COLLECT.
//      - If the word held last_px: on the write, set col=0, row=0.
//      - Also on that write: edge_count <= acc_cnt, acc_cnt <= 0, frame_done <= 1 for the next cycle.
//  - Latency: the word write is asserted in the first cycle after the 4th pixel pop, when out_full=0.
//  - Throughput: 4 pixels per 5 cycles at most (no pop while in S_EMIT).
//  - Back-pressure: while out_full=1 in S_EMIT, out_din and all state are held and no pops occur.
//  - Input gaps (in_empty=1): no pop, all state held. Word contents are unaffected by gap timing.
//  - in_rd_en is never asserted when in_empty=1. out_wr_en is never asserted when out_full=1.
//  - Frame boundary: next frame pixels are accepted the cycle after the final write (same cycle as frame_done).
//  - The final word of a frame is never merged with pixels of the next frame.
//  - Reset mid-frame: the partial word and partial counts are discarded and edge_count returns to 0.
//    - No write is issued in the reset cycle.
//    - The first pixel after reset is treated as col 0, row 0.
//  - acc_cnt saturates at no value: its width CNT_W already covers WIDTH*HEIGHT.
// TESTING
//  1. WIDTH=4 HEIGHT=2, push 01..08, out_full=0
//     -> writes 0x04030201 then 0x08070605; frame_done high 1 cycle after the 2nd write.
//  2. WIDTH=3 HEIGHT=1, push AA BB CC
//     -> single write 0x00CCBBAA; frame_done follows; the next frame's first word starts fresh.
//  3. Back-pressure: out_full=1 for 10 cycles while in S_EMIT
//     -> out_wr_en=0, in_rd_en=0, out_din constant; the write occurs the cycle out_full drops.
//  4. Random in_empty gaps (50%) on the test-1 stream
//     -> identical words and order; in_rd_en=0 whenever in_empty=1.
//  5. THRESHOLD=128, frame 00 80 7F FF 80 10 90 00
//     -> edge_count=4 at frame_done; value holds through the next frame until its frame_done.
//  6. Reset asserted after 5 of 8 pixels, then a full frame 01..08
//     -> no spurious write; output words 0x04030201, 0x08070605; edge_count reflects only the new frame.

Source files
------------

// File: rtl/edge_pixel_packer.sv
// edge_pixel_packer
//   Drains an 8-bit first-word-fall-through pixel FIFO and packs four pixels per 32-bit word
//   into a downstream FIFO. It tracks the column/row position over a WIDTH x HEIGHT frame and
//   zero-pads the last partial word of each frame. It also counts edge pixels
//   (pixel >= THRESHOLD) per frame and publishes the count with a one-cycle frame_done pulse.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high
//   in_dout     pixel at the head of the input FIFO (valid while !in_empty)
//   in_empty    input FIFO empty
//   in_rd_en    pop the input FIFO; in_dout is consumed in the same cycle
//   out_din     packed word; the first pixel is in [7:0], pixel k is in [8k+7:8k]
//   out_full    output FIFO full
//   out_wr_en   write out_din into the output FIFO
//   frame_done  one-cycle pulse in the cycle after the last word of a frame is written
//   edge_count  edge-pixel count of the last completed frame
module edge_pixel_packer #(
  parameter int unsigned WIDTH     = 720,
  parameter int unsigned HEIGHT    = 540,
  parameter int unsigned THRESHOLD = 128,
  parameter int unsigned CNT_W     = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       in_dout,
  input  logic             in_empty,
  output logic             in_rd_en,
  output logic [31:0]      out_din,
  input  logic             out_full,
  output logic             out_wr_en,
  output logic             frame_done,
  output logic [CNT_W-1:0] edge_count
);

  localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RowW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [ColW-1:0] ColLast = ColW'(WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(HEIGHT - 1);
  localparam logic [7:0]      Thresh  = 8'(THRESHOLD);

  typedef enum logic [0:0] {SCollect, SEmit} state_e;

  state_e            state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              last_q, last_d;        // held word closes the frame
  logic [CNT_W-1:0]  edge_count_q, edge_count_d;
  logic              frame_done_q, frame_done_d;
  logic              px_last;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    acc_cnt_d    = acc_cnt_q;
    last_d       = last_q;
    edge_count_d = edge_count_q;
    frame_done_d = 1'b0;
    in_rd_en     = 1'b0;
    out_wr_en    = 1'b0;
    px_last      = 1'b0;

    unique case (state_q)
      SCollect: begin
        in_rd_en = !in_empty;
        if (!in_empty) begin
          word_d[8*byte_idx_q +: 8] = in_dout;
          byte_idx_d = byte_idx_q + 2'd1;
          if (in_dout >= Thresh) begin
            acc_cnt_d = acc_cnt_q + 1'b1;
          end
          px_last = (col_q == ColLast) && (row_q == RowLast);
          if (col_q == ColLast) begin
            col_d = '0;
            // On the frame's last pixel the row stays put; it is cleared when the word is written.
            if (!px_last) begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
          last_d = px_last;
          if ((byte_idx_q == 2'd3) || px_last) begin
            state_d = SEmit;
          end
        end
      end
      SEmit: begin
        out_wr_en = !out_full;
        if (!out_full) begin
          word_d     = '0;
          byte_idx_d = '0;
          last_d     = 1'b0;
          state_d    = SCollect;
          if (last_q) begin
            col_d        = '0;
            row_d        = '0;
            edge_count_d = acc_cnt_q;
            acc_cnt_d    = '0;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = SCollect;
    endcase

    // Neither handshake may fire in a reset cycle; the state update is discarded anyway.
    if (reset) begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= SCollect;
      col_q        <= '0;
      row_q        <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      acc_cnt_q    <= '0;
      last_q       <= 1'b0;
      edge_count_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      acc_cnt_q    <= acc_cnt_d;
      last_q       <= last_d;
      edge_count_q <= edge_count_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_din    = word_q;
  assign frame_done = frame_done_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_edge_pixel_packer.sv
// Bench for edge_pixel_packer: a 4x2 instance (a) with random gaps and back-pressure and a
// 3x1 instance (b) for padded single-word frames. Expected words and edge counts are computed
// per frame from the pixel list; a handshake model checks rd/wr/frame_done timing every cycle.
module tb_edge_pixel_packer;

  localparam int WA = 4;
  localparam int HA = 2;
  localparam int NA = WA * HA;
  localparam int WB = 3;
  localparam int HB = 1;
  localparam int NB = WB * HB;
  localparam int Th = 128;
  localparam int CntWA = $clog2(NA + 1);
  localparam int CntWB = $clog2(NB + 1);

  logic             clock;
  logic             reset;
  logic [7:0]       in_dout_a, in_dout_b;
  logic             in_empty_a, in_empty_b;
  logic             in_rd_en_a, in_rd_en_b;
  logic [31:0]      out_din_a, out_din_b;
  logic             out_full_a, out_full_b;
  logic             out_wr_en_a, out_wr_en_b;
  logic             frame_done_a, frame_done_b;
  logic [CntWA-1:0] edge_count_a;
  logic [CntWB-1:0] edge_count_b;

  edge_pixel_packer #(.WIDTH(WA), .HEIGHT(HA), .THRESHOLD(Th), .CNT_W(CntWA)) u_dut_a (
    .clock      (clock),
    .reset      (reset),
    .in_dout    (in_dout_a),
    .in_empty   (in_empty_a),
    .in_rd_en   (in_rd_en_a),
    .out_din    (out_din_a),
    .out_full   (out_full_a),
    .out_wr_en  (out_wr_en_a),
    .frame_done (frame_done_a),
    .edge_count (edge_count_a)
  );

  edge_pixel_packer #(.WIDTH(WB), .HEIGHT(HB), .THRESHOLD(Th), .CNT_W(CntWB)) u_dut_b (
    .clock      (clock),
    .reset      (reset),
    .in_dout    (in_dout_b),
    .in_empty   (in_empty_b),
    .in_rd_en   (in_rd_en_b),
    .out_din    (out_din_b),
    .out_full   (out_full_b),
    .out_wr_en  (out_wr_en_b),
    .frame_done (frame_done_b),
    .edge_count (edge_count_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Source FIFOs and frame-level expectations
  logic [7:0]  src_a[$];
  logic [7:0]  src_b[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wb[$];
  int          exp_ea[$];
  int          exp_eb[$];
  int          gap_pct = 0;
  int          full_pct = 0;
  bit          full_force = 1'b0;
  bit          popped_a = 1'b0;
  bit          popped_b = 1'b0;

  task automatic push_frame_a(input logic [7:0] px [NA]);
    int cnt;
    logic [31:0] w;
    cnt = 0;
    for (int i = 0; i < NA; i += 4) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        if (i + k < NA) w = w | (32'(px[i+k]) << (8 * k));
      end
      exp_wa.push_back(w);
    end
    for (int i = 0; i < NA; i++) begin
      if (int'(px[i]) >= Th) cnt++;
      src_a.push_back(px[i]);
    end
    exp_ea.push_back(cnt);
  endtask

  task automatic push_frame_b(input logic [7:0] px [NB]);
    int cnt;
    logic [31:0] w;
    cnt = 0;
    w = '0;
    for (int i = 0; i < NB; i++) begin
      w = w | (32'(px[i]) << (8 * i));
      if (int'(px[i]) >= Th) cnt++;
      src_b.push_back(px[i]);
    end
    exp_wb.push_back(w);
    exp_eb.push_back(cnt);
  endtask

  // Source FIFO driver: pop what was consumed at the edge, then present the next head.
  initial begin
    in_empty_a = 1'b1;
    in_dout_a  = '0;
    out_full_a = 1'b0;
    in_empty_b = 1'b1;
    in_dout_b  = '0;
    out_full_b = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (popped_a && src_a.size() > 0) void'(src_a.pop_front());
      if (popped_b && src_b.size() > 0) void'(src_b.pop_front());
      if (src_a.size() > 0 && $urandom_range(99) >= gap_pct) begin
        in_empty_a = 1'b0;
        in_dout_a  = src_a[0];
      end else begin
        in_empty_a = 1'b1;
        in_dout_a  = 8'($urandom);
      end
      out_full_a = full_force || ($urandom_range(99) < full_pct);
      in_empty_b = (src_b.size() == 0);
      in_dout_b  = in_empty_b ? 8'h00 : src_b[0];
    end
  end

  // Handshake model and output checks, sampled mid-cycle
  bit               pend_a = 1'b0;
  bit               last_a = 1'b0;
  bit               exp_fd_a = 1'b0;
  bit               exp_fd_b = 1'b0;
  int               in_word_a = 0;
  int               pix_a = 0;
  logic [CntWA-1:0] exp_edge_a = '0;
  logic [CntWB-1:0] exp_edge_b = '0;

  initial begin
    bit exp_rd;
    bit exp_wr;
    forever begin
      @(negedge clock);
      if (reset) begin
        check("rst_rd_en_a", in_rd_en_a, 0);
        check("rst_wr_en_a", out_wr_en_a, 0);
        check("rst_wr_en_b", out_wr_en_b, 0);
        pend_a = 0; last_a = 0; exp_fd_a = 0; in_word_a = 0; pix_a = 0;
        exp_edge_a = '0; exp_fd_b = 0; exp_edge_b = '0;
        popped_a = 0; popped_b = 0;
      end else begin
        // instance a
        check("frame_done_a", frame_done_a, exp_fd_a);
        check("edge_count_a", edge_count_a, exp_edge_a);
        exp_rd = !pend_a && !in_empty_a;
        exp_wr = pend_a && !out_full_a;
        check("rd_en_a", in_rd_en_a, exp_rd);
        check("wr_en_a", out_wr_en_a, exp_wr);
        popped_a = in_rd_en_a && !in_empty_a;
        exp_fd_a = 0;
        if (pend_a) begin
          if (exp_wa.size() == 0) check("word_a_unexpected", 1, 0);
          else if (exp_wr) check("write_a", out_din_a, exp_wa[0]);
          else check("hold_a", out_din_a, exp_wa[0]);
        end
        if (exp_wr) begin
          if (exp_wa.size() > 0) void'(exp_wa.pop_front());
          pend_a = 0;
          in_word_a = 0;
          if (last_a) begin
            last_a = 0;
            pix_a = 0;
            exp_fd_a = 1;
            if (exp_ea.size() > 0) exp_edge_a = CntWA'(exp_ea.pop_front());
            else check("edge_a_unexpected", 1, 0);
          end
        end else if (exp_rd) begin
          in_word_a++;
          pix_a++;
          if (in_word_a == 4 || pix_a == NA) begin
            pend_a = 1;
            last_a = (pix_a == NA);
          end
        end
        // instance b
        check("frame_done_b", frame_done_b, exp_fd_b);
        check("edge_count_b", edge_count_b, exp_edge_b);
        check("rd_when_empty_b", in_rd_en_b && in_empty_b, 0);
        popped_b = in_rd_en_b && !in_empty_b;
        exp_fd_b = 0;
        if (out_wr_en_b) begin
          if (exp_wb.size() == 0) begin
            check("word_b_unexpected", 1, 0);
          end else begin
            check("write_b", out_din_b, exp_wb.pop_front());
            exp_fd_b = 1;
            if (exp_eb.size() > 0) exp_edge_b = CntWB'(exp_eb.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int cycles;
    cycles = 0;
    while ((src_a.size() > 0 || exp_wa.size() > 0 || src_b.size() > 0 || exp_wb.size() > 0)
           && cycles < budget) begin
      @(posedge clock);
      cycles++;
    end
    if (cycles >= budget) check("drain_timeout", 1, 0);
    repeat (3) @(posedge clock);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fa [NA];
    logic [7:0] fb [NB];

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    check("rst_out_din_a", out_din_a, 0);
    check("rst_out_din_b", out_din_b, 0);
    @(posedge clock);
    #2;

    // Padded single-word frames; the second frame's word must start clean.
    fb = '{8'hAA, 8'hBB, 8'hCC}; push_frame_b(fb);
    fb = '{8'h11, 8'h22, 8'h33}; push_frame_b(fb);
    fb = '{8'h80, 8'h7F, 8'h00}; push_frame_b(fb);
    wait_idle(200);

    // Basic 4x2 frame
    fa = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_frame_a(fa);
    wait_idle(200);

    // Back-pressure held across a stalled word while more pixels wait upstream
    full_force = 1'b1;
    push_frame_a(fa);
    repeat (16) @(posedge clock);
    #2 full_force = 1'b0;
    wait_idle(200);

    // Input gaps
    gap_pct = 50;
    push_frame_a(fa);
    push_frame_a(fa);
    wait_idle(400);

    // Random pixels with gaps and back-pressure
    gap_pct = 30;
    full_pct = 30;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < NA; i++) fa[i] = 8'($urandom);
      push_frame_a(fa);
    end
    wait_idle(4000);
    gap_pct = 0;
    full_pct = 0;

    // Threshold boundary values, then a frame whose count must not appear early
    fa = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h80, 8'h10, 8'h90, 8'h00};
    push_frame_a(fa);
    wait_idle(200);
    fa = '{8'hF0, 8'hF1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    push_frame_a(fa);
    wait_idle(200);

    // Reset mid-frame: 5 of 8 pixels accepted, then a fresh frame
    for (int i = 0; i < 5; i++) src_a.push_back(8'(8'h81 + i));
    exp_wa.push_back(32'h84838281);
    wait_idle(200);
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    fa = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_frame_a(fa);
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
